vga_sync_rx: RTL and testbench

- Receive side of the 2-bit-per-channel VGA link driven by the demo timing generator.
- Samples hsync, vsync and RGB in the same clk48 domain, recovers pixel coordinates and measures line length and frame height.
- Declares lock once timing is stable, and flags every active pixel with its (x, y).
- Used as an on-chip loopback checker and as a capture front end for the frame-compare bench.

---
 rtl/vga_sync_rx.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_vga_sync_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: receive side of the 2-bit-per-channel VGA link.
// Recovers pixel coordinates from hsync/vsync, measures line period and frame
// height, declares lock once timing is stable and flags every active pixel.
// Optional build macro FRAME_CRC_EN adds a per-frame CRC-16-CCITT over the
// 6-bit {r,g,b} value of every active pixel.
//
// Ports:
//   clk48        in   pixel/system clock
//   rst          in   synchronous reset, active-high
//   hsync_in     in   horizontal sync, active-low
//   vsync_in     in   vertical sync, active-low
//   r_in/g_in/b_in in 2-bit colour inputs
//   pix_valid    out  active pixel present on pix_* this cycle
//   pix_x/pix_y  out  pixel column / row
//   pix_r/g/b    out  registered colour of the pixel
//   frame_start  out  one-cycle pulse with pixel (0,0)
//   line_len     out  last measured hsync-rise to hsync-rise period
//   frame_lines  out  hsync rises counted in the last complete frame
//   locked       out  timing lock
//   lock_lost    out  one-cycle pulse when locked falls
//   frame_crc    out  (FRAME_CRC_EN) CRC of the last complete frame
//   crc_valid    out  (FRAME_CRC_EN) one-cycle pulse when frame_crc updates
module vga_sync_rx #(
    parameter int unsigned H_DISPLAY    = 1220,
    parameter int unsigned H_START      = 91,
    parameter int unsigned V_DISPLAY    = 480,
    parameter int unsigned V_BACK_PORCH = 33,
    parameter int unsigned H_TOL        = 2,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input  logic        clk48,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  r_in,
    input  logic [1:0]  g_in,
    input  logic [1:0]  b_in,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic [1:0]  pix_r,
    output logic [1:0]  pix_g,
    output logic [1:0]  pix_b,
    output logic        frame_start,
    output logic [11:0] line_len,
    output logic [9:0]  frame_lines,
    output logic        locked,
    output logic        lock_lost
`ifdef FRAME_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam int unsigned XW   = 11;
    localparam int unsigned YW   = 10;
    localparam int unsigned PW   = 12;
    localparam int unsigned DW   = PW + 1;
    localparam int unsigned CW   = 12;
    localparam int unsigned LFW  = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned LFW1 = LFW + 1;

    localparam logic [PW-1:0] PER_MAX = '1;
    localparam logic [XW-1:0] X_END   = XW'(H_DISPLAY);
    localparam logic [YW-1:0] Y_FIRST = YW'(V_BACK_PORCH);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_BACK_PORCH + V_DISPLAY - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Input stage; syncs reset to their idle (high) level so reset never fakes an edge.
    logic       hs1, hs2, vs1, vs2;
    logic [5:0] rgb1;

    always_ff @(posedge clk48) begin
        if (rst) begin
            hs1  <= 1'b1;
            hs2  <= 1'b1;
            vs1  <= 1'b1;
            vs2  <= 1'b1;
            rgb1 <= '0;
        end else begin
            hs1  <= hsync_in;
            hs2  <= hs1;
            vs1  <= vsync_in;
            vs2  <= vs1;
            rgb1 <= {r_in, g_in, b_in};
        end
    end

    logic [PW-1:0] per_cnt;
    logic [CW-1:0] cd;
    logic          arm, run;
    logic [XW-1:0] xr;
    logic [YW-1:0] lcnt;

    logic          h_rise, v_rise, timeout, h_dev;
    logic          x0, in_x, line_act, pv_nx, fs_nx;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic signed [DW-1:0] diff, adiff;

    // Event decode and position of the pixel currently held in stage 1.
    always_comb begin
        h_rise   = hs1 & ~hs2;
        v_rise   = vs1 & ~vs2;
        timeout  = (per_cnt == PER_MAX);
        diff     = $signed({1'b0, per_cnt}) - $signed({1'b0, line_len});
        adiff    = diff[DW-1] ? -diff : diff;
        h_dev    = h_rise && (adiff > $signed(DW'(H_TOL)));
        x0       = arm && (cd == '0);
        in_x     = x0 || (run && (xr != X_END));
        cur_x    = x0 ? '0 : xr;
        line_act = (lcnt >= Y_FIRST) && (lcnt <= Y_LAST);
        cur_y    = lcnt - Y_FIRST;
        pv_nx    = in_x && line_act && locked;
        fs_nx    = pv_nx && x0 && (cur_y == '0);
    end

    // Line period: counts cycles since the last hsync rise, saturating as timeout.
    always_ff @(posedge clk48) begin
        if (rst) begin
            per_cnt  <= '0;
            line_len <= '0;
        end else if (h_rise) begin
            per_cnt  <= PW'(1);
            line_len <= per_cnt;
        end else if (!timeout) begin
            per_cnt  <= per_cnt + PW'(1);
        end
    end

    // Horizontal position: H_START countdown, then x runs up to H_DISPLAY and holds.
    always_ff @(posedge clk48) begin
        if (rst) begin
            cd  <= '0;
            arm <= 1'b0;
            run <= 1'b0;
            xr  <= '0;
        end else if (h_rise) begin
            cd  <= CW'(H_START - 1);
            arm <= 1'b1;
            run <= 1'b0;
            xr  <= '0;
        end else if (x0) begin
            arm <= 1'b0;
            run <= 1'b1;
            xr  <= XW'(1);
        end else if (arm) begin
            cd  <= cd - CW'(1);
        end else if (run && (xr != X_END)) begin
            xr  <= xr + XW'(1);
        end
    end

    // Line counter; a coincident hsync rise counts after the vsync clear.
    always_ff @(posedge clk48) begin
        if (rst) begin
            lcnt        <= '0;
            frame_lines <= '0;
        end else if (v_rise) begin
            frame_lines <= lcnt;
            lcnt        <= h_rise ? YW'(1) : '0;
        end else if (h_rise && (lcnt != '1)) begin
            lcnt        <= lcnt + YW'(1);
        end
    end

    state_t         state, state_nx;
    logic [LFW-1:0] cons, cons_nx;
    logic           first_frame, first_nx;
    logic           frame_bad, bad_nx;
    logic           locked_nx, lock_lost_nx;
    logic           frame_ok;

    // State register.
    always_ff @(posedge clk48) begin
        if (rst) begin
            state       <= SEARCH;
            cons        <= '0;
            first_frame <= 1'b0;
            frame_bad   <= 1'b0;
        end else begin
            state       <= state_nx;
            cons        <= cons_nx;
            first_frame <= first_nx;
            frame_bad   <= bad_nx;
        end
    end

    // Next state; the first frame after SEARCH has no trusted height to compare with.
    always_comb begin
        state_nx = state;
        cons_nx  = cons;
        first_nx = first_frame;
        bad_nx   = frame_bad;
        frame_ok = !(frame_bad || h_dev || timeout) && (first_frame || (lcnt == frame_lines));
        case (state)
            SEARCH: begin
                if (v_rise) begin
                    state_nx = ACQUIRE;
                    cons_nx  = '0;
                    first_nx = 1'b1;
                    bad_nx   = 1'b0;
                end
            end
            ACQUIRE: begin
                if (v_rise) begin
                    first_nx = 1'b0;
                    bad_nx   = 1'b0;
                    if (!frame_ok) begin
                        cons_nx = '0;
                    end else if (LFW1'(cons) + LFW1'(1) >= LFW1'(LOCK_FRAMES)) begin
                        state_nx = LOCKED;
                        cons_nx  = '0;
                    end else begin
                        cons_nx = cons + LFW'(1);
                    end
                end else if (h_dev || timeout) begin
                    bad_nx = 1'b1;
                end
            end
            LOCKED: begin
                if (h_dev || timeout || (v_rise && (lcnt != frame_lines))) begin
                    state_nx = SEARCH;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    // Output decode.
    always_comb begin
        locked_nx    = (state_nx == LOCKED);
        lock_lost_nx = (state == LOCKED) && (state_nx != LOCKED);
    end

    // Registered outputs.
    always_ff @(posedge clk48) begin
        if (rst) begin
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
        end else begin
            locked      <= locked_nx;
            lock_lost   <= lock_lost_nx;
            pix_valid   <= pv_nx;
            frame_start <= fs_nx;
            if (x0 || run) begin
                pix_x <= in_x ? cur_x : (X_END - XW'(1));
            end
            if (x0 && line_act) begin
                pix_y <= cur_y;
            end
            if (pv_nx) begin
                {pix_r, pix_g, pix_b} <= rgb1;
            end
        end
    end

`ifdef FRAME_CRC_EN
    function automatic logic [15:0] crc6(input logic [15:0] c, input logic [5:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 5; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    logic [15:0] crc_acc;
    logic        crc_last, last_nx;

    always_comb begin
        last_nx = pv_nx && (cur_x == X_END - XW'(1)) && (cur_y == YW'(V_DISPLAY - 1));
    end

    // Accumulate in raster order; publish one cycle after the frame's last pixel.
    always_ff @(posedge clk48) begin
        if (rst) begin
            crc_acc   <= 16'hFFFF;
            crc_last  <= 1'b0;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            if (pv_nx) begin
                crc_acc <= crc6(fs_nx ? 16'hFFFF : crc_acc, rgb1);
            end
            crc_last  <= last_nx;
            crc_valid <= crc_last;
            if (crc_last) begin
                frame_crc <= crc_acc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: directed bench for vga_sync_rx on a scaled-down raster
// (20-cycle lines, 10-line frames, 8x4 active area) carrying a colour ramp.
module tb_vga_sync_rx;

    localparam int HD     = 8;
    localparam int HS     = 3;
    localparam int VD     = 4;
    localparam int VBP    = 3;
    localparam int TOL    = 2;
    localparam int LF     = 2;
    localparam int LINE   = 20;
    localparam int HSW    = 4;
    localparam int VSW    = 2;
    localparam int NLINES = 10;
    localparam int X0     = HSW + HS;
    localparam int Y0     = VSW + VBP - 1;

    logic        clk48, rst, hsync_in, vsync_in;
    logic [1:0]  r_in, g_in, b_in;
    logic        pix_valid, frame_start, locked, lock_lost;
    logic [10:0] pix_x;
    logic [9:0]  pix_y, frame_lines;
    logic [1:0]  pix_r, pix_g, pix_b;
    logic [11:0] line_len;
`ifdef FRAME_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
`endif

    vga_sync_rx #(
        .H_DISPLAY(HD), .H_START(HS), .V_DISPLAY(VD),
        .V_BACK_PORCH(VBP), .H_TOL(TOL), .LOCK_FRAMES(LF)
    ) dut (
        .clk48(clk48), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
        .locked(locked), .lock_lost(lock_lost)
`ifdef FRAME_CRC_EN
        , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    int checks = 0;
    int failures = 0;
    int pv_cnt = 0;
    int ll_cnt = 0;
    int ll0;
    logic [11:0] ll_last = '0;
    logic [11:0] ll_prev = '0;
    logic p_v = 1'b0;
    logic p_chk = 1'b0;
    int p_x = 0;
    int p_y = 0;
`ifdef FRAME_CRC_EN
    int crc_n = 0;
    logic [15:0] crc_a = '0;
    logic [15:0] crc_b = '0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of pins; outputs seen afterwards belong to the previous call's pins.
    task automatic tick(input logic h, input logic v, input int x, input int y,
                        input logic ev, input logic chk_en, input logic rs);
        hsync_in = h;
        vsync_in = v;
        rst      = rs;
        r_in     = 2'(x);
        g_in     = 2'(y);
        b_in     = 2'(x >> 2);
        @(negedge clk48);
        if (p_chk) begin
            chk("pix_valid_fs", {62'd0, pix_valid, frame_start},
                {62'd0, p_v, p_v && (p_x == 0) && (p_y == 0)});
            if (p_v)
                chk("pix_data", {34'd0, pix_x, pix_y, pix_r, pix_g, pix_b},
                    {34'd0, 11'(p_x), 10'(p_y), 2'(p_x), 2'(p_y), 2'(p_x >> 2)});
        end
        if (pix_valid === 1'b1) pv_cnt++;
        if (lock_lost === 1'b1) ll_cnt++;
        if (line_len !== ll_last) begin
            ll_prev = ll_last;
            ll_last = line_len;
        end
`ifdef FRAME_CRC_EN
        if (crc_valid === 1'b1) begin
            crc_a = crc_b;
            crc_b = frame_crc;
            crc_n++;
        end
`endif
        p_v   = ev;
        p_x   = x;
        p_y   = y;
        p_chk = chk_en;
    endtask

    // One frame: vsync low for lines 0..1, hsync low for cycles 0..3 of each line.
    task automatic gen_frame(input logic lk, input logic chk_en, input int st_gl,
                             input int st_len, input int rst_gl, input int rst_c);
        int len;
        int x;
        int y;
        logic ev;
        logic rs;
        for (int gl = 0; gl < NLINES; gl++) begin
            len = (gl == st_gl) ? st_len : LINE;
            for (int c = 0; c < len; c++) begin
                x  = c - X0;
                y  = gl - Y0;
                ev = lk && (y >= 0) && (y < VD) && (x >= 0) && (x < HD);
                rs = (gl == rst_gl) && (c == rst_c);
                tick(c >= HSW, gl >= VSW, x, y, ev, chk_en, rs);
                if (rs) begin
                    chk("reset_mid_line", {11'd0, pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b,
                        frame_start, line_len, frame_lines, locked, lock_lost}, 64'd0);
                    pv_cnt = 0;
                end
            end
        end
    endtask

`ifdef FRAME_CRC_EN
    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic [5:0]  d;
        c = 16'hFFFF;
        for (int y = 0; y < VD; y++) begin
            for (int x = 0; x < HD; x++) begin
                d = {2'(x), 2'(y), 2'(x >> 2)};
                for (int i = 5; i >= 0; i--)
                    c = (c << 1) ^ (((c[15] ^ d[i]) == 1'b1) ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction
`endif

    initial begin
        rst = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        r_in = '0;
        g_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk48);
        chk("reset_state", {11'd0, pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b,
            frame_start, line_len, frame_lines, locked, lock_lost}, 64'd0);
        rst = 1'b0;

        // Acquisition: lock at the vsync rise ending the second full frame.
        gen_frame(1'b0, 1'b1, -1, 0, -1, 0);
        gen_frame(1'b0, 1'b1, -1, 0, -1, 0);
        chk("locked_after_f1", {63'd0, locked}, 64'd0);
        chk("frame_lines_f1", {54'd0, frame_lines}, 64'd10);
        chk("line_len_f1", {52'd0, line_len}, 64'd20);
        pv_cnt = 0;
        gen_frame(1'b1, 1'b1, -1, 0, -1, 0);
        chk("locked_after_f2", {63'd0, locked}, 64'd1);
        chk("pv_count_f2", 64'(pv_cnt), 64'(HD * VD));

        // Line stretched by 3 cycles drops lock once; relock after two clean frames.
        gen_frame(1'b0, 1'b0, 5, LINE + 3, -1, 0);
        chk("locked_after_stretch", {63'd0, locked}, 64'd0);
        chk("lock_lost_count_1", 64'(ll_cnt), 64'd1);
        gen_frame(1'b0, 1'b1, -1, 0, -1, 0);
        gen_frame(1'b0, 1'b1, -1, 0, -1, 0);
        chk("locked_after_f5", {63'd0, locked}, 64'd0);
        gen_frame(1'b1, 1'b1, -1, 0, -1, 0);
        chk("relocked_f6", {63'd0, locked}, 64'd1);

        // Line stretched by 2 cycles stays within tolerance.
        gen_frame(1'b1, 1'b1, 5, LINE + 2, -1, 0);
        chk("locked_tol", {63'd0, locked}, 64'd1);
        chk("lock_lost_count_tol", 64'(ll_cnt), 64'd1);
        chk("line_len_stretched", {52'd0, ll_prev}, 64'd22);
        chk("line_len_restored", {52'd0, ll_last}, 64'd20);
        gen_frame(1'b1, 1'b1, -1, 0, -1, 0);

        // hsync stuck high: lock held until the period counter saturates.
        ll0 = ll_cnt;
        repeat (4000) tick(1'b1, 1'b1, -100, -100, 1'b0, 1'b0, 1'b0);
        chk("locked_before_timeout", {63'd0, locked}, 64'd1);
        repeat (1000) tick(1'b1, 1'b1, -100, -100, 1'b0, 1'b0, 1'b0);
        chk("locked_after_timeout", {63'd0, locked}, 64'd0);
        chk("lock_lost_timeout", 64'(ll_cnt), 64'(ll0 + 1));

        gen_frame(1'b0, 1'b1, -1, 0, -1, 0);
        gen_frame(1'b0, 1'b1, -1, 0, -1, 0);
        gen_frame(1'b1, 1'b1, -1, 0, -1, 0);
        chk("relocked_after_timeout", {63'd0, locked}, 64'd1);

        // Reset mid active line, then no pixels until relock.
        gen_frame(1'b0, 1'b0, -1, 0, Y0 + 1, X0 + 3);
        gen_frame(1'b0, 1'b1, -1, 0, -1, 0);
        gen_frame(1'b0, 1'b1, -1, 0, -1, 0);
        chk("pv_zero_after_reset", 64'(pv_cnt), 64'd0);
        chk("locked_before_relock", {63'd0, locked}, 64'd0);
`ifdef FRAME_CRC_EN
        crc_n = 0;
`endif
        pv_cnt = 0;
        gen_frame(1'b1, 1'b1, -1, 0, -1, 0);
        chk("relocked_after_reset", {63'd0, locked}, 64'd1);
        chk("pv_count_relock", 64'(pv_cnt), 64'(HD * VD));
        gen_frame(1'b1, 1'b1, -1, 0, -1, 0);
        chk("frame_lines_final", {54'd0, frame_lines}, 64'd10);
`ifdef FRAME_CRC_EN
        chk("crc_pulses", 64'(crc_n), 64'd2);
        chk("crc_equal", {48'd0, crc_a}, {48'd0, crc_b});
        chk("crc_model", {48'd0, crc_b}, {48'd0, model_crc()});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
